// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the data-memory responder: funct3 codes, FSM states,
// widths and the request legality helper.
package rv32_mem_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int CNTW = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  // Size code valid for the access direction and address aligned to that size.
  function automatic logic req_ok(input logic is_st, input logic [2:0] f3,
                                  input logic [1:0] lane);
    logic size_ok, algn_ok;
    if (is_st) size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
    algn_ok = 1'b1;
    if (f3[1:0] == 2'b01) algn_ok = !lane[0];
    if (f3 == F3_W)       algn_ok = (lane == 2'b00);
    return size_ok && algn_ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data and
// load lane selection with sign or zero extension.
module dmem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]      f3_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wword_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicate the datum across lanes, enable only the target bytes.
  always_comb begin
    be_o    = 4'b1111;
    wword_o = wdata_i;
    case (f3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed byte/half and extend to 32 bits.
  always_comb begin
    byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (f3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   rdata_o = {24'h0, byte_sel};
      F3_HU:   rdata_o = {16'h0, half_sel};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: checks and latches one load/store at a time, waits
// WAIT_STATES cycles, then performs the RAM access and responds for one cycle.
module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_r_en,
  input  logic            d_w_en,
  input  logic [XLEN-1:0] d_add,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [2:0]      f3,
  input  logic [REGW-1:0] req_rd,
  output logic            busy,
  output logic [XLEN-1:0] rd_data,
  output logic [REGW-1:0] wb_rd,
  output logic            wb_en,
  output logic            done,
  output logic            err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW   = IDXW + 2;

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]       addr_q;
  logic [XLEN-1:0]     wdata_q, rd_data_q;
  logic [2:0]          f3_q;
  logic [REGW-1:0]     rd_q;
  logic                st_q, err_q;
  logic [XLEN-1:0]     mem [DEPTH];

  logic                idle, req, bad, acc, go_resp;
  logic [AW-1:0]       a_addr;
  logic [XLEN-1:0]     a_wdata, rword, wword, ldata;
  logic [2:0]          a_f3;
  logic                a_st;
  logic [3:0]          be;

  assign idle = (state_q == ST_IDLE);
  assign req  = d_r_en ^ d_w_en;
  assign bad  = (d_r_en & d_w_en) |
                (req & (!req_ok(d_w_en, f3, d_add[1:0]) || (d_add[31:2] >= 30'(DEPTH))));
  assign acc  = idle & req & !bad;

  // With zero wait states the access happens straight out of IDLE, so the
  // RAM port sees the live request there and the latched copy otherwise.
  assign a_addr  = idle ? d_add[AW-1:0] : addr_q;
  assign a_wdata = idle ? d_wdata : wdata_q;
  assign a_f3    = idle ? f3 : f3_q;
  assign a_st    = idle ? d_w_en : st_q;
  assign rword   = mem[a_addr[AW-1:2]];

  dmem_lane_align u_align (
    .f3_i    (a_f3),
    .lane_i  (a_addr[1:0]),
    .wdata_i (a_wdata),
    .rword_i (rword),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (ldata)
  );

  // Next-state logic; go_resp marks the edge where the RAM is accessed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: if (acc) begin
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNTW'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: if (cnt_q == '0) begin
        state_d = ST_RESP;
        go_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latches, error strobe and held load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      st_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= idle & bad;
      if (acc) begin
        addr_q  <= d_add[AW-1:0];
        wdata_q <= d_wdata;
        f3_q    <= f3;
        rd_q    <= req_rd;
        st_q    <= d_w_en;
      end
      if (go_resp && !a_st) rd_data_q <= ldata;
    end
  end

  // RAM byte-enabled write; gated by reset so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (go_resp && a_st && rst) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_addr[AW-1:2]][8*i +: 8] <= wword[8*i +: 8];
    end
  end

  assign busy    = !idle;
  assign done    = (state_q == ST_RESP);
  assign wb_en   = done & !st_q;
  assign wb_rd   = wb_en ? rd_q : '0;
  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: word-array reference model, directed and random
// accesses on a one-wait-state instance, plus a zero-wait-state instance.
module tb_dmem_responder;

  localparam int DEPTH_A = 256;
  localparam int WS_A    = 1;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r_en = 0, w_en = 0;
  logic [31:0] add = 0, wdata = 0;
  logic [2:0]  f3 = 0;
  logic [4:0]  rd = 0;
  logic        busy, wben, done, err;
  logic [31:0] rdata;
  logic [4:0]  wbrd;

  logic        b_r = 0, b_w = 0;
  logic [31:0] b_add = 0, b_wdata = 0;
  logic [2:0]  b_f3 = 0;
  logic [4:0]  b_rd = 0;
  logic        b_busy, b_wben, b_done, b_err;
  logic [31:0] b_rdata;
  logic [4:0]  b_wbrd;

  dmem_responder #(.DEPTH(DEPTH_A), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .d_r_en(r_en), .d_w_en(w_en), .d_add(add),
    .d_wdata(wdata), .f3(f3), .req_rd(rd), .busy(busy), .rd_data(rdata),
    .wb_rd(wbrd), .wb_en(wben), .done(done), .err(err));

  dmem_responder #(.DEPTH(DEPTH_B), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .d_r_en(b_r), .d_w_en(b_w), .d_add(b_add),
    .d_wdata(b_wdata), .f3(b_f3), .req_rd(b_rd), .busy(b_busy), .rd_data(b_rdata),
    .wb_rd(b_wbrd), .wb_en(b_wben), .done(b_done), .err(b_err));

  int          tests = 0, fails = 0;
  logic [31:0] ref_mem [DEPTH_A];
  logic [31:0] last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_bad(bit r, bit w, logic [31:0] a, logic [2:0] f);
    if (r && w) return 1;
    if (w && f > 3'd2) return 1;
    if (!w && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
    if ((f == 3'd1 || f == 3'd5) && (a % 2) != 0) return 1;
    if (f == 3'd2 && (a % 4) != 0) return 1;
    if (a / 4 >= DEPTH_A) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f);
    logic [31:0] w, b, h;
    w = ref_mem[a / 4];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (f == 3'd2) begin ref_mem[a / 4] = d; return; end
    sh = (f == 3'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    m  = ((f == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    ref_mem[a / 4] = (ref_mem[a / 4] & ~m) | ((d << sh) & m);
  endtask

  // One access on instance A with full timing/response checking.
  task automatic acc_a(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic [4:0] rdi);
    bit          bad;
    int          cyc;
    logic [31:0] exp;
    bad = ref_bad(r, w, a, f);
    exp = (!bad && r && !w) ? ref_load(a, f) : 32'h0;
    @(negedge clk);
    r_en = r; w_en = w; add = a; wdata = d; f3 = f; rd = rdi;
    @(posedge clk);
    @(negedge clk);
    r_en = 0; w_en = 0;
    if (bad) begin
      chk("err_pulse", {31'h0, err}, 1);
      chk("err_busy", {31'h0, busy}, 0);
      chk("err_done", {31'h0, done | wben}, 0);
      @(negedge clk);
      chk("err_clear", {31'h0, err}, 0);
      chk("err_idle", {31'h0, busy}, 0);
    end else begin
      cyc = 1;
      while (!done && cyc < 20) begin
        chk("wait_busy", {31'h0, busy}, 1);
        @(negedge clk);
        cyc++;
      end
      chk("latency", cyc, 1 + WS_A);
      chk("resp_busy", {31'h0, busy}, 1);
      chk("resp_err", {31'h0, err}, 0);
      if (r) begin
        chk("wb_en", {31'h0, wben}, 1);
        chk("rd_data", rdata, exp);
        chk("wb_rd", {27'h0, wbrd}, {27'h0, rdi});
        last = exp;
      end else begin
        chk("st_wb_en", {31'h0, wben}, 0);
        chk("st_wb_rd", {27'h0, wbrd}, 0);
        chk("st_hold", rdata, last);
        ref_store(a, f, d);
      end
      @(negedge clk);
      chk("done_pulse", {31'h0, done}, 0);
      chk("back_idle", {31'h0, busy}, 0);
      chk("rd_hold", rdata, last);
    end
  endtask

  initial begin
    logic [31:0] old, k;
    bit          r, w;

    // reset state
    #2 rst = 0;
    #3;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_wben", {31'h0, wben}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wbrd", {27'h0, wbrd}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // preload every word so the model is fully defined
    for (int i = 0; i < DEPTH_A; i++) acc_a(0, 1, 4 * i, $urandom, 3'd2, 0);

    // directed
    acc_a(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0);
    acc_a(1, 0, 32'h10, 0, 3'd2, 5);
    acc_a(0, 1, 32'h11, 32'h80, 3'd0, 0);
    acc_a(1, 0, 32'h11, 0, 3'd0, 6);
    acc_a(1, 0, 32'h11, 0, 3'd4, 7);
    acc_a(1, 0, 32'h10, 0, 3'd2, 8);
    acc_a(0, 1, 32'h12, 32'h8001, 3'd1, 0);
    acc_a(1, 0, 32'h12, 0, 3'd1, 9);
    acc_a(1, 0, 32'h12, 0, 3'd5, 10);
    acc_a(1, 0, 32'h10, 0, 3'd2, 11);
    acc_a(1, 0, 32'h13, 0, 3'd2, 1);
    acc_a(1, 0, 32'h01, 0, 3'd1, 1);
    acc_a(1, 1, 32'h10, 32'h0, 3'd2, 1);
    acc_a(1, 0, 32'h10, 0, 3'd3, 1);
    acc_a(0, 1, 32'h10, 32'h1234, 3'd4, 1);
    acc_a(1, 0, 4 * DEPTH_A, 0, 3'd2, 1);
    acc_a(0, 1, 4 * DEPTH_A - 4, 32'hCAFEF00D, 3'd2, 0);
    acc_a(1, 0, 4 * DEPTH_A - 1, 0, 3'd0, 12);
    acc_a(1, 0, 32'h10, 0, 3'd2, 13);

    // random
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 1);
      w = !r;
      if ($urandom_range(0, 15) == 0) begin r = 1; w = 1; end
      acc_a(r, w, $urandom_range(0, 4 * DEPTH_A + 15), $urandom, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
    end

    // reset during the wait state of a store aborts it
    old = ref_mem[16];
    @(negedge clk);
    w_en = 1; add = 32'h40; wdata = ~old; f3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    w_en = 0;
    chk("abort_pre_busy", {31'h0, busy}, 1);
    rst = 0;
    #1;
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_done", {31'h0, done}, 0);
    chk("abort_rdata", rdata, 0);
    last = 0;
    @(negedge clk);
    rst = 1;
    acc_a(1, 0, 32'h40, 0, 3'd2, 3);

    // zero wait states: store, then back-to-back loads held high
    k = $urandom;
    @(negedge clk);
    b_w = 1; b_add = 32'h8; b_wdata = k; b_f3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    b_w = 0;
    chk("b_st_done", {31'h0, b_done}, 1);
    chk("b_st_busy", {31'h0, b_busy}, 1);
    @(negedge clk);
    chk("b_st_idle", {31'h0, b_busy | b_done}, 0);
    b_r = 1; b_f3 = 3'd2; b_rd = 5'd7;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_done_seq", {31'h0, b_done}, 32'(i % 2));
      chk("b_busy_seq", {31'h0, b_busy}, 32'(i % 2));
      if (i % 2 == 1) begin
        chk("b_rdata", b_rdata, k);
        chk("b_wbrd", {27'h0, b_wbrd}, 7);
      end
    end
    b_r = 0;
    @(negedge clk);
    b_r = 1; b_add = 4 * DEPTH_B;
    @(posedge clk);
    @(negedge clk);
    b_r = 0;
    chk("b_range_err", {31'h0, b_err}, 1);
    chk("b_range_busy", {31'h0, b_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
